// File: rtl/sdram_prefetch_buffer_pkg.sv
// Shared types and helpers for the one-line SDRAM read-prefetch buffer.
package sdram_pf_pkg;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FILL,
    S_WR,
    S_DONE
  } pf_state_t;

  function automatic logic [DEF_DATA_W-1:0] byte_merge(
    input logic [DEF_DATA_W-1:0] old_word,
    input logic [DEF_DATA_W-1:0] new_word,
    input logic [3:0]            sel
  );
    logic [DEF_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdram_prefetch_buffer_if.sv
// Wishbone slave-side bus and SDRAM controller request/return bus.
interface sdram_pf_wb_if #(parameter int DATA_W = 32);
  logic              wbs_stb_i;
  logic              wbs_cyc_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic [31:0]       wbs_adr_i;
  logic              wbs_ack_o;
  logic [DATA_W-1:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

interface sdram_pf_ctrl_if #(parameter int ADDR_W = 23, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_rw;
  logic [DATA_W-1:0] ctrl_data_in;
  logic [3:0]        ctrl_mask;
  logic              ctrl_in_valid;
  logic              ctrl_busy;
  logic [DATA_W-1:0] ctrl_data_out;
  logic              ctrl_out_valid;

  modport master (
    output ctrl_addr, ctrl_rw, ctrl_data_in, ctrl_mask, ctrl_in_valid,
    input  ctrl_busy, ctrl_data_out, ctrl_out_valid
  );
  modport slave (
    input  ctrl_addr, ctrl_rw, ctrl_data_in, ctrl_mask, ctrl_in_valid,
    output ctrl_busy, ctrl_data_out, ctrl_out_valid
  );
endinterface

// File: rtl/sdram_prefetch_buffer_line_buf.sv
// Prefetch line storage: byte-enabled write port, asynchronous indexed read.
module pf_line_buf
  import sdram_pf_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = 8,
  localparam int LW        = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        be,
  input  logic [LW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);

  // No reset: contents are meaningful only while the owner's line_valid is set.
  logic [DATA_W-1:0] mem [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= byte_merge(mem[widx], wdata, be);
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/sdram_prefetch_buffer.sv
// One-line read-prefetch buffer between the Wishbone slave and sdram_controller.
//   state  | meaning
//   IDLE   | sample a new request
//   HIT    | ack a read from the line
//   FILL   | stream LINE_WORDS reads into the line, ack when complete
//   WR     | pass write through, merge into line on hit, then ack
//   DONE   | guard cycle so a held request is not re-sampled
module sdram_prefetch_buffer
  import sdram_pf_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = 8,
  parameter int MAX_OUT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_pf_wb_if.slave          wb,
  sdram_pf_ctrl_if.master       ctrl,
  input  logic                  inv_i,
  output logic [15:0]           hit_cnt_o,
  output logic [15:0]           miss_cnt_o
);

  localparam int LW    = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - LW - 2;
  localparam int CW    = LW + 1;

  pf_state_t state, state_nx;

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag, req_tag;
  logic [LW-1:0]     req_off;
  logic [CW-1:0]     iss, rcv;
  logic              inv_seen, wr_acc;
  logic [DATA_W-1:0] dat_q;

  logic              req, hit, issue_ok, accept, fill_last, fill_done;
  logic [TAG_W-1:0]  adr_tag;
  logic [LW-1:0]     adr_off;

  logic              ack_c, in_valid_c, rw_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_in_c;
  logic [3:0]        mask_c;

  logic              lb_we;
  logic [LW-1:0]     lb_widx;
  logic [DATA_W-1:0] lb_wdata, line_rdata;
  logic [3:0]        lb_be;

  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb.wbs_adr_i[31:ADDR_W], wb.wbs_adr_i[1:0]};

  assign req       = wb.wbs_stb_i & wb.wbs_cyc_i;
  assign adr_tag   = wb.wbs_adr_i[ADDR_W-1:LW+2];
  assign adr_off   = wb.wbs_adr_i[LW+1:2];
  assign hit       = line_valid && (line_tag == adr_tag);
  assign issue_ok  = (iss < CW'(LINE_WORDS)) && ((iss - rcv) < CW'(MAX_OUT));
  assign fill_done = (rcv == CW'(LINE_WORDS));
  assign fill_last = (state == S_FILL) && ctrl.ctrl_out_valid && (rcv == CW'(LINE_WORDS - 1));
  assign accept    = in_valid_c && !ctrl.ctrl_busy;

  pf_line_buf #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) u_line (
    .clk   (clk),
    .we    (lb_we),
    .widx  (lb_widx),
    .wdata (lb_wdata),
    .be    (lb_be),
    .ridx  (adr_off),
    .rdata (line_rdata)
  );

  always_comb begin
    state_nx   = state;
    ack_c      = 1'b0;
    in_valid_c = 1'b0;
    rw_c       = 1'b0;
    addr_c     = '0;
    data_in_c  = '0;
    mask_c     = 4'b0000;
    lb_we      = 1'b0;
    lb_widx    = rcv[LW-1:0];
    lb_wdata   = ctrl.ctrl_data_out;
    lb_be      = 4'hF;
    case (state)
      S_IDLE: begin
        if (req) state_nx = wb.wbs_we_i ? S_WR : (hit ? S_HIT : S_FILL);
      end
      S_HIT: begin
        ack_c    = 1'b1;
        state_nx = S_DONE;
      end
      S_FILL: begin
        if (issue_ok) begin
          in_valid_c = 1'b1;
          addr_c     = {req_tag, iss[LW-1:0], 2'b00};
        end
        if (ctrl.ctrl_out_valid && !fill_done) lb_we = 1'b1;
        // Ack only if the requester is still waiting; an abandoned read completes silently.
        if (fill_done) begin
          ack_c    = req;
          state_nx = S_DONE;
        end
      end
      S_WR: begin
        if (wr_acc) begin
          ack_c    = 1'b1;
          state_nx = S_DONE;
        end else if (!req) begin
          state_nx = S_IDLE;
        end else begin
          in_valid_c = 1'b1;
          rw_c       = 1'b1;
          addr_c     = wb.wbs_adr_i[ADDR_W-1:0];
          data_in_c  = wb.wbs_dat_i;
          mask_c     = wb.wbs_sel_i;
          if (!ctrl.ctrl_busy && hit) begin
            lb_we    = 1'b1;
            lb_widx  = adr_off;
            lb_wdata = wb.wbs_dat_i;
            lb_be    = wb.wbs_sel_i;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      line_valid <= 1'b0;
      line_tag   <= '0;
      req_tag    <= '0;
      req_off    <= '0;
      iss        <= '0;
      rcv        <= '0;
      inv_seen   <= 1'b0;
      wr_acc     <= 1'b0;
      dat_q      <= '0;
      hit_cnt_o  <= 16'd0;
      miss_cnt_o <= 16'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (req && !wb.wbs_we_i) begin
            req_tag <= adr_tag;
            req_off <= adr_off;
            if (hit) begin
              dat_q <= line_rdata;
              if (hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
            end else begin
              if (miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
              iss      <= '0;
              rcv      <= '0;
              inv_seen <= 1'b0;
            end
          end
        end
        S_FILL: begin
          if (accept) iss <= iss + CW'(1);
          if (ctrl.ctrl_out_valid && !fill_done) begin
            rcv <= rcv + CW'(1);
            if (rcv[LW-1:0] == req_off) dat_q <= ctrl.ctrl_data_out;
          end
          if (inv_i) inv_seen <= 1'b1;
          if (fill_last) line_tag <= req_tag;
        end
        S_WR:    wr_acc <= accept;
        default: ;
      endcase

      if (inv_i || (state == S_IDLE && req && !wb.wbs_we_i && !hit)) begin
        line_valid <= 1'b0;
      end else if (fill_last && !inv_seen) begin
        line_valid <= 1'b1;
      end
    end
  end

  assign wb.wbs_ack_o       = ack_c;
  assign wb.wbs_dat_o       = dat_q;
  assign ctrl.ctrl_in_valid = in_valid_c;
  assign ctrl.ctrl_rw       = rw_c;
  assign ctrl.ctrl_addr     = addr_c;
  assign ctrl.ctrl_data_in  = data_in_c;
  assign ctrl.ctrl_mask     = mask_c;

endmodule
